// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares the single mem_ctrl burst interface between two
// clients. Round-robin between channels, write beats read within a channel,
// and each grant is held for exactly one burst followed by one GAP cycle.
module mem_burst_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 24,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  phy_clk,
  input  logic                  rst_n,
  input  logic                  init_calib_complete,
  // channel 0 client side
  input  logic                  ch0_wr_burst_req,
  input  logic                  ch0_rd_burst_req,
  input  logic [LEN_WIDTH-1:0]  ch0_wr_burst_len,
  input  logic [LEN_WIDTH-1:0]  ch0_rd_burst_len,
  input  logic [ADDR_WIDTH-1:0] ch0_wr_burst_addr,
  input  logic [ADDR_WIDTH-1:0] ch0_rd_burst_addr,
  input  logic [DATA_WIDTH-1:0] ch0_wr_burst_data,
  output logic                  ch0_wr_burst_data_req,
  output logic                  ch0_rd_burst_data_valid,
  output logic [DATA_WIDTH-1:0] ch0_rd_burst_data,
  output logic                  ch0_wr_burst_finish,
  output logic                  ch0_rd_burst_finish,
  // channel 1 client side
  input  logic                  ch1_wr_burst_req,
  input  logic                  ch1_rd_burst_req,
  input  logic [LEN_WIDTH-1:0]  ch1_wr_burst_len,
  input  logic [LEN_WIDTH-1:0]  ch1_rd_burst_len,
  input  logic [ADDR_WIDTH-1:0] ch1_wr_burst_addr,
  input  logic [ADDR_WIDTH-1:0] ch1_rd_burst_addr,
  input  logic [DATA_WIDTH-1:0] ch1_wr_burst_data,
  output logic                  ch1_wr_burst_data_req,
  output logic                  ch1_rd_burst_data_valid,
  output logic [DATA_WIDTH-1:0] ch1_rd_burst_data,
  output logic                  ch1_wr_burst_finish,
  output logic                  ch1_rd_burst_finish,
  // mem_ctrl side
  output logic                  wr_burst_req,
  output logic                  rd_burst_req,
  output logic [LEN_WIDTH-1:0]  wr_burst_len,
  output logic [LEN_WIDTH-1:0]  rd_burst_len,
  output logic [ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [ADDR_WIDTH-1:0] rd_burst_addr,
  output logic [DATA_WIDTH-1:0] wr_burst_data,
  input  logic                  wr_burst_data_req,
  input  logic                  wr_burst_finish,
  input  logic                  rd_burst_data_valid,
  input  logic                  rd_burst_finish,
  input  logic [DATA_WIDTH-1:0] rd_burst_data,
  // status
  output logic                  busy,
  output logic                  owner
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] GAP  = 2'd3;

  logic [1:0] state;
  logic       last_owner;
  logic       ch0_cand;
  logic       ch1_cand;
  logic       grant_any;
  logic       grant_ch;
  logic       grant_wr;
  logic       in_wr;
  logic       in_rd;

  // On contention the channel that did not go last wins; a lone requester
  // always wins. Inside the winning channel a write outranks a read.
  assign ch0_cand  = ch0_wr_burst_req | ch0_rd_burst_req;
  assign ch1_cand  = ch1_wr_burst_req | ch1_rd_burst_req;
  assign grant_any = init_calib_complete & (ch0_cand | ch1_cand);
  assign grant_ch  = (ch0_cand & ch1_cand) ? ~last_owner : ch1_cand;
  assign grant_wr  = grant_ch ? ch1_wr_burst_req : ch0_wr_burst_req;

  // Grant FSM: latch owner and the winner's address/length, hold the
  // registered downstream request until the matching finish, then idle one GAP.
  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      owner         <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_req  <= 1'b0;
      wr_burst_addr <= '0;
      wr_burst_len  <= '0;
      rd_burst_addr <= '0;
      rd_burst_len  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner      <= grant_ch;
            last_owner <= grant_ch;
            if (grant_wr) begin
              wr_burst_req  <= 1'b1;
              wr_burst_addr <= grant_ch ? ch1_wr_burst_addr : ch0_wr_burst_addr;
              wr_burst_len  <= grant_ch ? ch1_wr_burst_len : ch0_wr_burst_len;
              state         <= WR;
            end else begin
              rd_burst_req  <= 1'b1;
              rd_burst_addr <= grant_ch ? ch1_rd_burst_addr : ch0_rd_burst_addr;
              rd_burst_len  <= grant_ch ? ch1_rd_burst_len : ch0_rd_burst_len;
              state         <= RD;
            end
          end
        end
        WR: begin
          if (wr_burst_finish) begin
            wr_burst_req <= 1'b0;
            state        <= GAP;
          end
        end
        RD: begin
          if (rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            state        <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshakes are routed combinationally to the owner only and only in the
  // matching direction; write data is zeroed outside a write so reset clears it.
  assign in_wr = (state == WR);
  assign in_rd = (state == RD);
  assign busy  = in_wr | in_rd;

  assign wr_burst_data           = in_wr ? (owner ? ch1_wr_burst_data : ch0_wr_burst_data) : '0;
  assign ch0_wr_burst_data_req   = in_wr & ~owner & wr_burst_data_req;
  assign ch1_wr_burst_data_req   = in_wr &  owner & wr_burst_data_req;
  assign ch0_wr_burst_finish     = in_wr & ~owner & wr_burst_finish;
  assign ch1_wr_burst_finish     = in_wr &  owner & wr_burst_finish;
  assign ch0_rd_burst_data_valid = in_rd & ~owner & rd_burst_data_valid;
  assign ch1_rd_burst_data_valid = in_rd &  owner & rd_burst_data_valid;
  assign ch0_rd_burst_finish     = in_rd & ~owner & rd_burst_finish;
  assign ch1_rd_burst_finish     = in_rd &  owner & rd_burst_finish;
  assign ch0_rd_burst_data       = rd_burst_data;
  assign ch1_rd_burst_data       = rd_burst_data;

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// tb_mem_burst_arbiter: client models and a mem_ctrl model drive the arbiter;
// stimulus pushes expected grants into a queue and a negedge monitor pops and
// checks each downstream grant, its beats, routing and finish.
module tb_mem_burst_arbiter;

  logic        phy_clk = 1'b0;
  logic        rst_n;
  logic        init_calib_complete;
  logic        ch0_wr_burst_req, ch0_rd_burst_req, ch1_wr_burst_req, ch1_rd_burst_req;
  logic [9:0]  ch0_wr_burst_len, ch0_rd_burst_len, ch1_wr_burst_len, ch1_rd_burst_len;
  logic [23:0] ch0_wr_burst_addr, ch0_rd_burst_addr, ch1_wr_burst_addr, ch1_rd_burst_addr;
  logic [63:0] ch0_wr_burst_data, ch1_wr_burst_data;
  logic        ch0_wr_burst_data_req, ch0_rd_burst_data_valid, ch0_wr_burst_finish, ch0_rd_burst_finish;
  logic        ch1_wr_burst_data_req, ch1_rd_burst_data_valid, ch1_wr_burst_finish, ch1_rd_burst_finish;
  logic [63:0] ch0_rd_burst_data, ch1_rd_burst_data;
  logic        wr_burst_req, rd_burst_req;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic [23:0] wr_burst_addr, rd_burst_addr;
  logic [63:0] wr_burst_data;
  logic        wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish;
  logic [63:0] rd_burst_data;
  logic        busy, owner;

  typedef struct {
    bit          is_wr;
    bit          ch;
    logic [23:0] addr;
    logic [9:0]  len;
  } exp_t;

  exp_t exp_q[$];
  int   assert_count = 0;
  int   fail_count   = 0;

  mem_burst_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(24), .LEN_WIDTH(10)) dut (
    .phy_clk(phy_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .ch0_wr_burst_req(ch0_wr_burst_req), .ch0_rd_burst_req(ch0_rd_burst_req),
    .ch0_wr_burst_len(ch0_wr_burst_len), .ch0_rd_burst_len(ch0_rd_burst_len),
    .ch0_wr_burst_addr(ch0_wr_burst_addr), .ch0_rd_burst_addr(ch0_rd_burst_addr),
    .ch0_wr_burst_data(ch0_wr_burst_data), .ch0_wr_burst_data_req(ch0_wr_burst_data_req),
    .ch0_rd_burst_data_valid(ch0_rd_burst_data_valid), .ch0_rd_burst_data(ch0_rd_burst_data),
    .ch0_wr_burst_finish(ch0_wr_burst_finish), .ch0_rd_burst_finish(ch0_rd_burst_finish),
    .ch1_wr_burst_req(ch1_wr_burst_req), .ch1_rd_burst_req(ch1_rd_burst_req),
    .ch1_wr_burst_len(ch1_wr_burst_len), .ch1_rd_burst_len(ch1_rd_burst_len),
    .ch1_wr_burst_addr(ch1_wr_burst_addr), .ch1_rd_burst_addr(ch1_rd_burst_addr),
    .ch1_wr_burst_data(ch1_wr_burst_data), .ch1_wr_burst_data_req(ch1_wr_burst_data_req),
    .ch1_rd_burst_data_valid(ch1_rd_burst_data_valid), .ch1_rd_burst_data(ch1_rd_burst_data),
    .ch1_wr_burst_finish(ch1_wr_burst_finish), .ch1_rd_burst_finish(ch1_rd_burst_finish),
    .wr_burst_req(wr_burst_req), .rd_burst_req(rd_burst_req),
    .wr_burst_len(wr_burst_len), .rd_burst_len(rd_burst_len),
    .wr_burst_addr(wr_burst_addr), .rd_burst_addr(rd_burst_addr),
    .wr_burst_data(wr_burst_data), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_finish(wr_burst_finish), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_finish(rd_burst_finish), .rd_burst_data(rd_burst_data),
    .busy(busy), .owner(owner)
  );

  // 100 MHz phy_clk
  always #5 phy_clk = ~phy_clk;

  function automatic logic [63:0] pat(input bit ch);
    pat = ch ? 64'h5A5A_5A5A_5A5A_5A5A : 64'hA5A5_A5A5_A5A5_A5A5;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assert_count++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // mem_ctrl model: on a downstream request, streams len strobes then a
  // one-cycle finish; abandons the burst if reset is asserted.
  task automatic memServe(input bit is_wr, input int len);
    for (int b = 0; b < len; b++) begin
      @(posedge phy_clk); #1;
      if (!rst_n) begin
        wr_burst_data_req = 0; rd_burst_data_valid = 0;
        return;
      end
      if (is_wr) wr_burst_data_req = 1;
      else begin
        rd_burst_data_valid = 1;
        rd_burst_data = 64'hD000 + 64'(b);
      end
    end
    @(posedge phy_clk); #1;
    wr_burst_data_req = 0; rd_burst_data_valid = 0;
    if (!rst_n) return;
    if (is_wr) wr_burst_finish = 1; else rd_burst_finish = 1;
    @(posedge phy_clk); #1;
    wr_burst_finish = 0; rd_burst_finish = 0;
  endtask

  initial begin
    wr_burst_data_req = 0; wr_burst_finish = 0;
    rd_burst_data_valid = 0; rd_burst_finish = 0; rd_burst_data = '0;
    forever begin
      @(negedge phy_clk);
      if (rst_n && wr_burst_req) memServe(1'b1, int'(wr_burst_len));
      else if (rst_n && rd_burst_req) memServe(1'b0, int'(rd_burst_len));
    end
  end

  // Client model: raise one request, hold until its finish (or reset), drop it.
  task automatic client(input bit ch, input bit is_wr, input logic [23:0] addr, input logic [9:0] len);
    int  n = 0;
    bit  done = 0;
    bit  fin;
    case ({ch, is_wr})
      2'b01: begin ch0_wr_burst_addr = addr; ch0_wr_burst_len = len; ch0_wr_burst_req = 1; end
      2'b00: begin ch0_rd_burst_addr = addr; ch0_rd_burst_len = len; ch0_rd_burst_req = 1; end
      2'b11: begin ch1_wr_burst_addr = addr; ch1_wr_burst_len = len; ch1_wr_burst_req = 1; end
      default: begin ch1_rd_burst_addr = addr; ch1_rd_burst_len = len; ch1_rd_burst_req = 1; end
    endcase
    while (!done) begin
      @(negedge phy_clk);
      n++;
      case ({ch, is_wr})
        2'b01:   fin = ch0_wr_burst_finish;
        2'b00:   fin = ch0_rd_burst_finish;
        2'b11:   fin = ch1_wr_burst_finish;
        default: fin = ch1_rd_burst_finish;
      endcase
      if (!rst_n || fin) done = 1;
      else if (n > 4000) begin
        checkOutput($sformatf("client_timeout_ch%0d_wr%0d", ch, is_wr), 64'(0), 64'(1));
        done = 1;
      end
    end
    @(posedge phy_clk); #1;
    case ({ch, is_wr})
      2'b01:   ch0_wr_burst_req = 0;
      2'b00:   ch0_rd_burst_req = 0;
      2'b11:   ch1_wr_burst_req = 0;
      default: ch1_rd_burst_req = 0;
    endcase
  endtask

  task automatic pushExp(input bit is_wr, input bit ch, input logic [23:0] addr, input logic [9:0] len);
    exp_t e;
    e.is_wr = is_wr; e.ch = ch; e.addr = addr; e.len = len;
    exp_q.push_back(e);
  endtask

  // Monitor: pops an expected grant on each rising downstream request and
  // checks routing/data per beat, beat count at finish, and bus turnaround.
  initial begin
    exp_t cur;
    bit   in_burst = 0;
    bit   prev_req = 0;
    bit   busy_chk = 0;
    int   gap = 100;
    int   beats = 0;
    bit   req_now;
    cur.is_wr = 0; cur.ch = 0; cur.addr = '0; cur.len = '0;
    forever begin
      @(negedge phy_clk);
      if (!rst_n) begin
        in_burst = 0; prev_req = 0; busy_chk = 0; gap = 100; beats = 0;
      end else begin
        req_now = wr_burst_req | rd_burst_req;
        if (busy_chk) begin
          checkOutput("busy_after_finish", 64'(busy), 64'(0));
          busy_chk = 0;
        end
        if (req_now && !prev_req) begin
          if (exp_q.size() == 0) checkOutput("unexpected_grant", 64'(0), 64'(1));
          else begin
            cur = exp_q.pop_front();
            checkOutput("grant_owner", 64'(owner), 64'(cur.ch));
            checkOutput("grant_dir_wr", 64'(wr_burst_req), 64'(cur.is_wr));
            checkOutput("grant_dir_rd", 64'(rd_burst_req), 64'(!cur.is_wr));
            checkOutput("grant_addr", 64'(cur.is_wr ? wr_burst_addr : rd_burst_addr), 64'(cur.addr));
            checkOutput("grant_len", 64'(cur.is_wr ? wr_burst_len : rd_burst_len), 64'(cur.len));
            checkOutput("grant_busy", 64'(busy), 64'(1));
            checkOutput("turnaround_ge2", 64'(gap >= 2), 64'(1));
            in_burst = 1; beats = 0;
          end
        end
        if (req_now) gap = 0; else gap++;
        if (in_burst) begin
          if (wr_burst_data_req) begin
            checkOutput("wr_data_req_route", 64'({ch1_wr_burst_data_req, ch0_wr_burst_data_req}),
                        64'(cur.ch ? 2'b10 : 2'b01));
            checkOutput("wr_data_mux", wr_burst_data, pat(cur.ch));
            beats++;
          end
          if (rd_burst_data_valid) begin
            checkOutput("rd_valid_route", 64'({ch1_rd_burst_data_valid, ch0_rd_burst_data_valid}),
                        64'(cur.ch ? 2'b10 : 2'b01));
            checkOutput("rd_data_bcast0", ch0_rd_burst_data, rd_burst_data);
            checkOutput("rd_data_bcast1", ch1_rd_burst_data, rd_burst_data);
            beats++;
          end
          if ((cur.is_wr && wr_burst_finish) || (!cur.is_wr && rd_burst_finish)) begin
            if (cur.is_wr)
              checkOutput("wr_finish_route", 64'({ch1_wr_burst_finish, ch0_wr_burst_finish}),
                          64'(cur.ch ? 2'b10 : 2'b01));
            else
              checkOutput("rd_finish_route", 64'({ch1_rd_burst_finish, ch0_rd_burst_finish}),
                          64'(cur.ch ? 2'b10 : 2'b01));
            checkOutput("beat_count", 64'(beats), 64'(cur.len));
            in_burst = 0; busy_chk = 1;
          end
        end
        prev_req = req_now;
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_reqs"}, 64'({wr_burst_req, rd_burst_req}), 64'(0));
    checkOutput({tag, "_busy_owner"}, 64'({busy, owner}), 64'(0));
    checkOutput({tag, "_addrs"}, 64'({wr_burst_addr, rd_burst_addr}), 64'(0));
    checkOutput({tag, "_lens"}, 64'({wr_burst_len, rd_burst_len}), 64'(0));
    checkOutput({tag, "_wr_data"}, wr_burst_data, 64'(0));
    checkOutput({tag, "_strobes"}, 64'({ch0_wr_burst_data_req, ch1_wr_burst_data_req,
                ch0_rd_burst_data_valid, ch1_rd_burst_data_valid, ch0_wr_burst_finish,
                ch1_wr_burst_finish, ch0_rd_burst_finish, ch1_rd_burst_finish}), 64'(0));
  endtask

  task automatic applyStimulus();
    int n;
    // reset and calibration gate, then a single ch0 write
    rst_n = 0; init_calib_complete = 0;
    ch0_wr_burst_req = 0; ch0_rd_burst_req = 0; ch1_wr_burst_req = 0; ch1_rd_burst_req = 0;
    ch0_wr_burst_len = 0; ch0_rd_burst_len = 0; ch1_wr_burst_len = 0; ch1_rd_burst_len = 0;
    ch0_wr_burst_addr = 0; ch0_rd_burst_addr = 0; ch1_wr_burst_addr = 0; ch1_rd_burst_addr = 0;
    ch0_wr_burst_data = pat(1'b0); ch1_wr_burst_data = pat(1'b1);
    repeat (3) @(negedge phy_clk);
    checkAllZero("reset");
    rst_n = 1;
    $display("[TB] calibration gate and single write");
    pushExp(1'b1, 1'b0, 24'h000100, 10'd128);
    fork
      client(1'b0, 1'b1, 24'h000100, 10'd128);
      begin
        repeat (5) begin
          @(negedge phy_clk);
          checkOutput("calib_gate_wr_req", 64'(wr_burst_req), 64'(0));
        end
        @(posedge phy_clk); #1;
        init_calib_complete = 1;
        @(posedge phy_clk);
        @(negedge phy_clk);
        checkOutput("calib_grant_latency", 64'(wr_burst_req), 64'(1));
        checkOutput("calib_grant_owner", 64'(owner), 64'(0));
      end
    join
    repeat (3) @(posedge phy_clk);

    $display("[TB] intra-channel write priority on ch1");
    pushExp(1'b1, 1'b1, 24'h010000, 10'd8);
    pushExp(1'b0, 1'b1, 24'h020000, 10'd4);
    fork
      client(1'b1, 1'b1, 24'h010000, 10'd8);
      client(1'b1, 1'b0, 24'h020000, 10'd4);
    join
    repeat (3) @(posedge phy_clk);

    $display("[TB] read contention round-robin");
    pushExp(1'b0, 1'b0, 24'h200000, 10'd64);
    pushExp(1'b0, 1'b1, 24'h300000, 10'd64);
    pushExp(1'b0, 1'b0, 24'h200040, 10'd64);
    pushExp(1'b0, 1'b1, 24'h300040, 10'd64);
    fork
      begin
        client(1'b0, 1'b0, 24'h200000, 10'd64);
        @(posedge phy_clk); #1;
        client(1'b0, 1'b0, 24'h200040, 10'd64);
      end
      begin
        client(1'b1, 1'b0, 24'h300000, 10'd64);
        @(posedge phy_clk); #1;
        client(1'b1, 1'b0, 24'h300040, 10'd64);
      end
    join
    repeat (3) @(posedge phy_clk);

    $display("[TB] reset in the middle of a ch1 write");
    pushExp(1'b1, 1'b1, 24'h0ABCDE, 10'd128);
    fork
      client(1'b1, 1'b1, 24'h0ABCDE, 10'd128);
      begin
        n = 0;
        while (n < 10) begin
          @(negedge phy_clk);
          if (wr_burst_data_req && busy) n++;
        end
        #2;
        rst_n = 0;
        #1;
        checkAllZero("async_reset");
        repeat (3) @(negedge phy_clk);
        rst_n = 1;
        @(negedge phy_clk);
        checkAllZero("after_reset");
      end
    join
    repeat (2) @(posedge phy_clk); #1;

    $display("[TB] write contention after reset, data routing");
    pushExp(1'b1, 1'b0, 24'h000400, 10'd16);
    pushExp(1'b1, 1'b1, 24'h000800, 10'd16);
    fork
      client(1'b0, 1'b1, 24'h000400, 10'd16);
      client(1'b1, 1'b1, 24'h000800, 10'd16);
    join
    repeat (5) @(negedge phy_clk);
    checkOutput("expected_grants_left", 64'(exp_q.size()), 64'(0));
    checkOutput("final_idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    fail_count++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Two-channel arbiter that shares the single burst interface of `mem_ctrl` (DDR3 MCB wrapper) between two independent clients, each with its own read and write burst ports. It sits between client logic (for example `mem_test`, video frame readers and writers) and `mem_ctrl`, all in the `phy_clk` domain. Arbitration is round-robin between channels, with write priority inside a channel. A grant is held for exactly one burst, until the matching finish.

## Interface
- `DATA_WIDTH`, 64, burst data width; matches `mem_ctrl` `MEM_DATA_BITS`.
- `ADDR_WIDTH`, 24, burst address width; matches `mem_ctrl` `ADDR_BITS`.
- `LEN_WIDTH`, 10, burst length width.

Ports:
- `phy_clk`  in  1  single clock; the `mem_ctrl` user clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `init_calib_complete`  in  1  no grant is issued while this is low.
- `chN_wr_burst_req`, `chN_rd_burst_req`  in  1 each  level requests for channel N (N=0,1); held until the channel's finish.
- `chN_wr_burst_len`, `chN_rd_burst_len`  in  LEN_WIDTH  burst lengths; stable while the request is high.
- `chN_wr_burst_addr`, `chN_rd_burst_addr`  in  ADDR_WIDTH  burst start addresses; stable while the request is high.
- `chN_wr_burst_data`  in  DATA_WIDTH  write data for channel N.
- `chN_wr_burst_data_req`  out  1  write data strobe, routed to the owning channel only.
- `chN_rd_burst_data_valid`  out  1  read data valid, routed to the owning channel only.
- `chN_rd_burst_data`  out  DATA_WIDTH  read data, broadcast to both channels.
- `chN_wr_burst_finish`, `chN_rd_burst_finish`  out  1 each  finish pulses, routed to the owning channel only.
- `wr_burst_req`, `rd_burst_req`  out  1 each  requests to `mem_ctrl`.
- `wr_burst_len`, `rd_burst_len`  out  LEN_WIDTH  lengths to `mem_ctrl`.
- `wr_burst_addr`, `rd_burst_addr`  out  ADDR_WIDTH  addresses to `mem_ctrl`.
- `wr_burst_data`  out  DATA_WIDTH  write data to `mem_ctrl`.
- `wr_burst_data_req`, `wr_burst_finish`, `rd_burst_data_valid`, `rd_burst_finish`  in  1 each  `mem_ctrl` handshakes.
- `rd_burst_data`  in  DATA_WIDTH  read data from `mem_ctrl`.
- `busy`  out  1  a grant is active (state WR or RD).
- `owner`  out  1  channel currently or last granted.

## Operation
State machine with four states: IDLE, WR, RD, GAP.

- **IDLE**
  - Candidate channels are those with either request high.
  - If both channels are candidates, grant the channel that is not `last_owner`.
  - If only one channel is a candidate, grant that channel.
  - Within the granted channel, a write beats a read when both are high.
  - On grant: latch `owner`, and latch that channel's address and length into the downstream address/length registers.
  - Set `last_owner` = granted channel; go to WR or RD.
  - No grant while `init_calib_complete` = 0.
- **WR**
  - `wr_burst_req` = 1.
  - `wr_burst_data` = `ch[owner]_wr_burst_data`, combinational mux.
  - `wr_burst_data_req` and `wr_burst_finish` are forwarded combinationally to the owner; the other channel sees 0.
  - On `wr_burst_finish` = 1, go to GAP.
- **RD**
  - `rd_burst_req` = 1.
  - `rd_burst_data_valid` and `rd_burst_finish` are forwarded combinationally to the owner only.
  - `rd_burst_data` goes to both channels unconditionally.
  - On `rd_burst_finish` = 1, go to GAP.
- **GAP**
  - One cycle, with both downstream requests 0.
  - Lets the finished client drop its request before the next arbitration; go to IDLE.
- Downstream requests are registered, and the address/length outputs hold their latched values until the next grant.
- Handshake inputs of the wrong direction (for example `rd_burst_finish` while in WR) are ignored and not forwarded.

## Timing
- Reset values:
  - All outputs 0; state IDLE; `last_owner` = 1, so channel 0 wins the first contention.
  - `owner` = 0, `busy` = 0.
  - Address/length registers 0.
- **Grant latency:** a request sampled high in IDLE at edge k gives downstream `*_burst_req` = 1 and `busy` = 1 after edge k.
- **Release:** finish high at edge f gives downstream req = 0 after edge f (state GAP).
  - IDLE after f+1; the earliest next downstream req is after f+2.
  - Minimum bus turnaround: 2 idle cycles.
- Forwarded handshakes (`data_req`, `data_valid`, `finish`, `wr_burst_data`) add zero-cycle latency.
- A request that drops while in IDLE before being granted is simply not served.
- A client dropping its request mid-burst is a protocol violation; the arbiter keeps the grant until finish.
- `rst_n` low mid-burst: all outputs clear immediately and the state goes to IDLE. `mem_ctrl` shares the same `rst_n`.
- `init_calib_complete` falling mid-burst: the burst completes normally; new grants are blocked afterwards.

## Test plan
- **Reset/calibration gate:** hold `init_calib_complete` = 0, raise `ch0_wr_burst_req` -> `wr_burst_req` stays 0. Raise calib -> `wr_burst_req` = 1 one cycle later with `owner` = 0.
- **Single write:** ch0 write, addr 0x000100, len 128 -> `wr_burst_addr` = 0x000100, `wr_burst_len` = 128.
  - 128 `ch0_wr_burst_data_req` pulses, 0 on ch1.
  - `ch0_wr_burst_finish` mirrors `mem_ctrl`; `busy` falls the cycle after finish.
- **Contention round-robin:** ch0 and ch1 both request reads continuously, len 64 -> grant order ch0, ch1, ch0, ch1.
  - `rd_burst_data_valid` counts of 64 go only to the owner each time.
  - At least 2 idle cycles between downstream requests.
- **Intra-channel priority:** ch1 raises write and read together, ch0 idle -> write served first, then the read after GAP.
- **Data routing:** ch0 write data = 0xA5A5..., ch1 = 0x5A5A... -> `wr_burst_data` equals the owner's pattern during each burst; a scoreboard of `mem_ctrl` writes matches per channel.
- **Reset mid-burst:** assert `rst_n` = 0 at beat 10 of a 128-beat write -> all outputs 0 asynchronously.
  - After release, `last_owner` = 1, so the first contention is granted to ch0.
